// File: rtl/cordic_iter_ctrl.sv
// Hyperbolic CORDIC iteration sequencer: steers the operand mux, enables the datapath register and emits the shift/ROM index.
// BEG to LOAD in one cycle, LOAD to ITER in one, result held in DONE until ACK; every output comes from a register.
module cordic_iter_ctrl #(
  parameter int N_ITER = 16,
  parameter int W_IDX  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BEG,
  input  logic             ACK,
  output logic             MS,
  output logic             EN_REG,
  output logic [W_IDX-1:0] IDX,
  output logic             BUSY,
  output logic             READY
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  localparam logic [W_IDX-1:0] LP_LAST  = W_IDX'(N_ITER);
  localparam logic [W_IDX-1:0] LP_REP_A = W_IDX'(4);
  localparam logic [W_IDX-1:0] LP_REP_B = W_IDX'(13);
  localparam logic [W_IDX-1:0] LP_ONE   = W_IDX'(1);

  state_t           r_state, w_state_nxt;
  logic [W_IDX-1:0] r_idx, w_idx_nxt;
  logic             r_rep, w_rep_nxt;
  logic             r_ms, r_en, r_busy, r_ready;
  logic             w_ms_nxt, w_en_nxt, w_busy_nxt, w_ready_nxt;
  logic             w_is_rep;

  assign w_is_rep = (r_idx == LP_REP_A) || (r_idx == LP_REP_B);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rep_nxt   = r_rep;
    case (r_state)
      S_IDLE: begin
        if (BEG) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = LP_ONE;
        end
      end
      S_LOAD: w_state_nxt = S_ITER;
      S_ITER: begin
        // Repeat indices run twice; the flag marks that the first pass is done.
        if (w_is_rep && !r_rep) begin
          w_rep_nxt = 1'b1;
        end else begin
          w_rep_nxt = 1'b0;
          if (r_idx == LP_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + LP_ONE;
          end
        end
      end
      S_DONE: begin
        if (ACK) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_rep_nxt   = 1'b0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    w_ms_nxt    = (w_state_nxt == S_ITER) || (w_state_nxt == S_DONE);
    w_en_nxt    = (w_state_nxt == S_LOAD) || (w_state_nxt == S_ITER);
    w_busy_nxt  = (w_state_nxt == S_LOAD) || (w_state_nxt == S_ITER);
    w_ready_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rep   <= 1'b0;
      r_ms    <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rep   <= w_rep_nxt;
      r_ms    <= w_ms_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign MS     = r_ms;
  assign EN_REG = r_en;
  assign IDX    = r_idx;
  assign BUSY   = r_busy;
  assign READY  = r_ready;

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter N_ITER, 16, last hyperbolic CORDIC iteration index (legal range 5..31).
REQ-002 Parameter W_IDX, 5, width of the iteration index output.
REQ-003 The module SHALL provide the following ports, clock and reset first:
- CLK  input  1  single system clock; all state changes on its rising edge.
- RST  input  1  asynchronous active-low reset.
- BEG  input  1  start request, sampled only in IDLE.
- ACK  input  1  consumer acknowledge of the finished result, sampled only in DONE.
- MS  output  1  select for the downstream Mux_2x1 (0 = initial operand D_0, 1 = feedback D_1).
- EN_REG  output  1  load enable for the datapath register behind the mux.
- IDX  output  W_IDX  current CORDIC shift/ROM index.
- BUSY  output  1  high in LOAD and ITER.
- READY  output  1  result valid, high in DONE.

Function
REQ-004 All outputs SHALL be registered Moore outputs decoded from the state register; no input-to-output combinational path.
REQ-005 The FSM SHALL have four states: IDLE, LOAD, ITER and DONE.
REQ-006 IDLE: MS=0, EN_REG=0, BUSY=0, READY=0, IDX=0; BEG=1 -> LOAD on the next edge.
REQ-007 LOAD lasts exactly 1 cycle: MS=0, EN_REG=1, BUSY=1, IDX=1; it SHALL unconditionally transition to ITER.
REQ-008 ITER: MS=1, EN_REG=1, BUSY=1.
REQ-009 In ITER, indices 4 and 13 SHALL each be executed twice (hyperbolic convergence repeat), tracked by an internal 1-bit repeat flag.
REQ-010 ITER update rule: if IDX is 4 or 13 and the flag is 0, set the flag and hold IDX; otherwise clear the flag and increment IDX.
REQ-011 ITER SHALL exit to DONE after the cycle in which IDX=N_ITER; a repeat index 13 equal to N_ITER SHALL be repeated before exit.
REQ-012 With N_ITER=16, the IDX sequence in ITER SHALL be 1,2,3,4,4,5..13,13,14,15,16 (18 cycles).
REQ-013 Latency: BEG sampled at edge k -> LOAD in cycle k+1, ITER in cycles k+2..k+19, READY=1 from cycle k+20 (N_ITER=16).
REQ-014 DONE: MS=1, EN_REG=0 (result frozen in the register), BUSY=0, READY=1, IDX holds N_ITER.
REQ-015 DONE SHALL be held indefinitely until ACK=1; ACK=1 -> IDLE on the next edge.
REQ-016 BEG in LOAD, ITER or DONE SHALL be ignored and not queued; BEG=1 together with ACK=1 in DONE SHALL go to IDLE only, and a new BEG is required there.
REQ-017 ACK outside DONE SHALL be ignored.
REQ-018 The IDX counter SHALL never exceed N_ITER and SHALL never wrap.

Reset
REQ-019 RST=0 SHALL immediately, without waiting for CLK, force IDLE, flag=0, IDX=0, MS=0, EN_REG=0, BUSY=0 and READY=0.
REQ-020 Reset asserted mid-ITER SHALL abort the operation; after release, the block SHALL wait for a fresh BEG.
REQ-021 Reset release SHALL be taken synchronously; BEG on the first edge after release SHALL be accepted.

Verification
REQ-022 Nominal run: BEG pulse at edge 0 -> the 18-cycle IDX trace of REQ-012 with MS=1; READY=1 at cycle 20 and held 50 cycles without ACK; ACK -> IDLE next cycle.
REQ-023 Mux integration: drive Mux_2x1 with D_0=32'h00000004 and D_1=32'h80000001 under MS -> the mux output equals 32'h00000004 in LOAD and 32'h80000001 in ITER/DONE.
REQ-024 BEG held high for the whole run -> exactly one operation; the next LOAD occurs only after ACK plus a BEG seen in IDLE.
REQ-025 RST pulled low at cycle 10 (IDX=8), between clock edges -> all outputs reach reset values before the next edge; the subsequent BEG gives the full sequence from IDX=1.
REQ-026 Simultaneous BEG=1 and ACK=1 in DONE -> IDLE with READY=0 and no new LOAD.
REQ-027 N_ITER=13 -> ITER sequence 1..4,4,5..13,13 (15 cycles), then DONE with IDX=13.
